// File: rtl/sprite_anim_seq_pkg.sv
// Shared types and constants for the sprite animation sequencer.
package sprite_pkg;

  typedef enum logic {IDLE, WALK} anim_state_t;

  typedef logic [3:0] sprite_state_t;

  localparam int FRAMES_PER_ANIM = 4;

  localparam logic [1:0] DIR_DOWN  = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;
  localparam logic [1:0] DIR_UP    = 2'd3;

  // Plain walk-cycle successor: 0,1,2,3,0,...
  function automatic logic [1:0] next_frame_wrap(logic [1:0] f);
    return (f == 2'(FRAMES_PER_ANIM - 1)) ? 2'd0 : f + 2'd1;
  endfunction

endpackage

// File: rtl/sprite_anim_seq_if.sv
// Handshake bundle between game/input logic and the sprite sequencer.
interface sprite_anim_seq_if;
  import sprite_pkg::*;

  logic          frame_tick;
  logic          move_en;
  logic [1:0]    dir;
  sprite_state_t sprite_state;
  logic          step;

  modport master (output frame_tick, move_en, dir, input sprite_state, step);
  modport slave  (input frame_tick, move_en, dir, output sprite_state, step);
endinterface

// File: rtl/sprite_anim_seq_frame_div.sv
// Frame-tick divider: counts ticks while enabled, pulses adv on the tick
// that completes FRAME_DIV ticks. clr zeroes the count and masks adv.
module sprite_frame_div #(
  parameter int FRAME_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic adv
);
  localparam int W = $clog2(FRAME_DIV + 1);
  localparam logic [W-1:0] LAST = W'(FRAME_DIV - 1);

  logic [W-1:0] cnt;
  logic         at_last;

  assign at_last = (cnt == LAST);
  assign adv     = en & ~clr & at_last;

  // Tick counter; a clear wins over a coincident tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= at_last ? '0 : cnt + W'(1);
  end
endmodule

// File: rtl/sprite_anim_seq.sv
// Sprite animation sequencer: 4-frame walk cycle per facing direction,
// advanced every FRAME_DIV frame ticks. Output {group, frame} is registered.
// Optional: define SPRITE_PINGPONG_EN for a 0,1,2,3,2,1,0,... sequence.
module sprite_anim_seq
  import sprite_pkg::*;
#(
  parameter int FRAME_DIV = 8
) (
  input logic              clk,
  input logic              rst_n,
  sprite_anim_seq_if.slave bif
);
  anim_state_t state;
  logic [1:0]  group;
  logic [1:0]  frame;
  logic        step_q;
  logic        dir_chg;
  logic        div_clr;
  logic        div_adv;
`ifdef SPRITE_PINGPONG_EN
  logic        pp_up;
`endif

  assign dir_chg = (bif.dir != group);
  // Divider only runs while walking with no direction change pending.
  assign div_clr = dir_chg | (state == IDLE) | ~bif.move_en;

  sprite_frame_div #(.FRAME_DIV(FRAME_DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (div_clr),
    .en    (bif.frame_tick),
    .adv   (div_adv)
  );

  // Walk FSM plus group/frame registers; dir change > stop > advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      group  <= 2'd0;
      frame  <= 2'd0;
      step_q <= 1'b0;
`ifdef SPRITE_PINGPONG_EN
      pp_up  <= 1'b1;
`endif
    end else begin
      step_q <= 1'b0;
      state  <= bif.move_en ? WALK : IDLE;
      if (dir_chg) begin
        group <= bif.dir;
        frame <= 2'd0;
`ifdef SPRITE_PINGPONG_EN
        pp_up <= 1'b1;
`endif
      end else if (state == IDLE || !bif.move_en) begin
        frame <= 2'd0;
`ifdef SPRITE_PINGPONG_EN
        pp_up <= 1'b1;
`endif
      end else if (div_adv) begin
        step_q <= 1'b1;
`ifdef SPRITE_PINGPONG_EN
        if (pp_up) begin
          if (frame == 2'd3) begin
            frame <= 2'd2;
            pp_up <= 1'b0;
          end else begin
            frame <= frame + 2'd1;
          end
        end else begin
          if (frame == 2'd0) begin
            frame <= 2'd1;
            pp_up <= 1'b1;
          end else begin
            frame <= frame - 2'd1;
          end
        end
`else
        frame <= next_frame_wrap(frame);
`endif
      end
    end
  end

  assign bif.sprite_state = {group, frame};
  assign bif.step         = step_q;
endmodule

// File: tb/tb_sprite_anim_seq.sv
// Bench for sprite_anim_seq: two instances (FRAME_DIV=2 and FRAME_DIV=1)
// share one stimulus stream and are checked against a position-in-sequence
// model every cycle, plus directed scenarios with literal expectations.
module tb_sprite_anim_seq;
  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick  = 1'b0;
  logic       men   = 1'b0;
  logic [1:0] dir   = 2'd0;

  always #5 clk = ~clk;

  sprite_anim_seq_if if0();
  sprite_anim_seq_if if1();

  assign if0.frame_tick = tick;
  assign if0.move_en    = men;
  assign if0.dir        = dir;
  assign if1.frame_tick = tick;
  assign if1.move_en    = men;
  assign if1.dir        = dir;

  sprite_anim_seq #(.FRAME_DIV(2)) dut0 (.clk(clk), .rst_n(rst_n), .bif(if0));
  sprite_anim_seq #(.FRAME_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bif(if1));

`ifdef SPRITE_PINGPONG_EN
  localparam int SEQ_LEN = 6;
  int exp_pp [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
`else
  localparam int SEQ_LEN = 4;
  int exp_pp [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
`endif
  int seqtab [6] = '{0, 1, 2, 3, 2, 1};
  int fd     [2] = '{2, 1};
  int exp_w  [8] = '{4, 5, 5, 6, 6, 7, 7, 4};

  // Model: group, position in the frame sequence, ticks since last clear.
  int m_grp [2];
  int m_pos [2];
  int m_tk  [2];
  bit m_walk[2];
  bit m_step[2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_grp[i] = 0; m_pos[i] = 0; m_tk[i] = 0; m_walk[i] = 0; m_step[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      m_step[i] = 0;
      if (int'(dir) != m_grp[i]) begin
        m_grp[i] = int'(dir); m_pos[i] = 0; m_tk[i] = 0;
      end else if (!m_walk[i] || !men) begin
        m_pos[i] = 0; m_tk[i] = 0;
      end else if (tick) begin
        m_tk[i]++;
        if (m_tk[i] == fd[i]) begin
          m_tk[i]   = 0;
          m_pos[i]  = (m_pos[i] + 1) % SEQ_LEN;
          m_step[i] = 1;
        end
      end
      m_walk[i] = men;
    end
  endtask

  task automatic compare();
    chk("model_ss0",   int'(if0.sprite_state), m_grp[0] * 4 + seqtab[m_pos[0]]);
    chk("model_step0", int'(if0.step),         int'(m_step[0]));
    chk("model_ss1",   int'(if1.sprite_state), m_grp[1] * 4 + seqtab[m_pos[1]]);
    chk("model_step1", int'(if1.step),         int'(m_step[1]));
  endtask

  // One clock cycle with the given tick; called and returns at a negedge.
  task automatic cyc(input logic tk);
    tick = tk;
    @(posedge clk);
    model_edge();
    #1 compare();
    @(negedge clk);
    tick = 1'b0;
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ss",   int'(if0.sprite_state), 0);
    chk("rst_step", int'(if0.step), 0);
    rst_n = 1'b1;

    // Standing still: ticks ignored.
    men = 1'b0;
    repeat (20) begin
      cyc(1'b1);
      chk("idle_ss",   int'(if0.sprite_state), 0);
      chk("idle_step", int'(if0.step), 0);
    end

    // Group 1 walk, FRAME_DIV=2.
    dir = 2'd1; cyc(1'b0);
    chk("dir1_ss", int'(if0.sprite_state), 4);
    men = 1'b1; cyc(1'b0);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1);
      chk("walk_ss",   int'(if0.sprite_state), exp_w[k]);
      chk("walk_step", int'(if0.step), (k % 2 == 1) ? 1 : 0);
      cyc(1'b0);
    end

    // Direction change mid-walk at sprite_state 10.
    dir = 2'd2; cyc(1'b0);
    chk("dir2_ss", int'(if0.sprite_state), 8);
    repeat (4) begin cyc(1'b1); cyc(1'b0); end
    chk("at10_ss", int'(if0.sprite_state), 10);
    dir = 2'd3; cyc(1'b0);
    chk("dirchg_ss",   int'(if0.sprite_state), 12);
    chk("dirchg_step", int'(if0.step), 0);
    cyc(1'b1);
    chk("dirchg_t1", int'(if0.sprite_state), 12);
    cyc(1'b0); cyc(1'b1);
    chk("dirchg_t2",   int'(if0.sprite_state), 13);
    chk("dirchg_step2", int'(if0.step), 1);
    cyc(1'b0);

    // move_en drop coincident with completing tick at 6.
    dir = 2'd1; cyc(1'b0);
    repeat (4) begin cyc(1'b1); cyc(1'b0); end
    chk("at6_ss", int'(if0.sprite_state), 6);
    cyc(1'b1); cyc(1'b0);
    men = 1'b0; cyc(1'b1);
    chk("stop_ss",   int'(if0.sprite_state), 4);
    chk("stop_step", int'(if0.step), 0);
    cyc(1'b1); cyc(1'b1);
    chk("stop_idle", int'(if0.sprite_state), 4);

    // Asynchronous reset mid-walk at 14.
    dir = 2'd3; men = 1'b1; cyc(1'b0);
    repeat (4) begin cyc(1'b1); cyc(1'b0); end
    chk("at14_ss", int'(if0.sprite_state), 14);
    #2 rst_n = 1'b0; men = 1'b0; dir = 2'd0;
    #1;
    chk("arst_ss0",  int'(if0.sprite_state), 0);
    chk("arst_step", int'(if0.step), 0);
    chk("arst_ss1",  int'(if1.sprite_state), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cyc(1'b1);
    chk("post_rst_ss", int'(if0.sprite_state), 0);

    // FRAME_DIV=1 sequence on group 0 (ping-pong when configured).
    men = 1'b1; cyc(1'b0);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1);
      chk("seq_fd1", int'(if1.sprite_state), exp_pp[k]);
      cyc(1'b0);
    end

    // Randomized traffic against the model.
    repeat (3000) begin
      if ($urandom_range(0, 19) == 0) dir = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) men = ~men;
      cyc($urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
